memory_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the write stage's store interface plus the read stage's load port.

---
 rtl/memory_responder_pkg.sv | 17 +
 rtl/memory_responder_watchdog.sv | 28 ++
 rtl/memory_responder.sv | 133 +++++++++++++
 tb/tb_memory_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
package memory_responder_pkg;

    typedef logic [31:0] regval_t;

    localparam int      MEM_ADDR_WIDTH = 14;
    localparam regval_t MEM_ERROR_WORD = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_REQ,
        READ_WAIT,
        DONE
    } mem_state_t;

endpackage

// File: rtl/memory_responder_watchdog.sv
// Transaction watchdog: counts busy cycles and flags expiry at TIMEOUT-1.
module memory_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Holds at LAST so a stuck owner keeps seeing expiry rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/memory_responder.sv
// Store/load responder driving a waitrequest-style memory bus; one-cycle completion pulses.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int      ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int      TIMEOUT    = 256,
    parameter regval_t ERROR_WORD = MEM_ERROR_WORD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  regval_t               write_address,
    input  regval_t               write_data,
    output logic                  write_valid,
    input  logic                  read_enable,
    input  regval_t               read_address,
    output regval_t               read_data,
    output logic                  read_valid,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write,
    output logic                  mem_read,
    output regval_t               mem_writedata,
    input  regval_t               mem_readdata,
    input  logic                  mem_waitrequest,
    input  logic                  mem_readdatavalid,
    output mem_state_t            state
);

    logic expired;
    logic wd_clear;
    logic wd_enable;

    assign wd_clear  = (state == IDLE);
    assign wd_enable = (state == WRITE) || (state == READ_REQ) || (state == READ_WAIT);

    memory_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (expired)
    );

    // Byte offset and bits above the memory window are dropped, so addresses wrap.
    logic unused_address_bits;
    assign unused_address_bits = ^{write_address[31:ADDR_WIDTH+2], write_address[1:0],
                                   read_address[31:ADDR_WIDTH+2], read_address[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            write_valid   <= 1'b0;
            read_valid    <= 1'b0;
            error         <= 1'b0;
            mem_write     <= 1'b0;
            mem_read      <= 1'b0;
            read_data     <= '0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else begin
            write_valid <= 1'b0;
            read_valid  <= 1'b0;
            error       <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Stores are older in the pipeline, so they win a tie.
                    if (write_enable) begin
                        mem_address   <= write_address[ADDR_WIDTH+1:2];
                        mem_writedata <= write_data;
                        mem_write     <= 1'b1;
                        state         <= WRITE;
                    end else if (read_enable) begin
                        mem_address <= read_address[ADDR_WIDTH+1:2];
                        mem_read    <= 1'b1;
                        state       <= READ_REQ;
                    end
                end
                WRITE: begin
                    if (expired || !mem_waitrequest) begin
                        mem_write   <= 1'b0;
                        write_valid <= 1'b1;
                        error       <= expired;
                        state       <= DONE;
                    end
                end
                READ_REQ: begin
                    if (expired) begin
                        mem_read   <= 1'b0;
                        read_valid <= 1'b1;
                        error      <= 1'b1;
                        read_data  <= ERROR_WORD;
                        state      <= DONE;
                    end else if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        if (mem_readdatavalid) begin
                            read_data  <= mem_readdata;
                            read_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (expired) begin
                        read_valid <= 1'b1;
                        error      <= 1'b1;
                        read_data  <= ERROR_WORD;
                        state      <= DONE;
                    end else if (mem_readdatavalid) begin
                        read_data  <= mem_readdata;
                        read_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Requesters must hold their enable until the matching valid pulse.
    write_held: assert property (@(posedge clock) disable iff (reset)
        (state == WRITE) |-> write_enable);
    read_held: assert property (@(posedge clock) disable iff (reset)
        ((state == READ_REQ) || (state == READ_WAIT)) |-> read_enable);

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: scripted memory responses plus a completion scoreboard.
module tb_memory_responder;
    import memory_responder_pkg::*;

    localparam int AW = 14;
    localparam int TO = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic            write_enable;
    regval_t         write_address;
    regval_t         write_data;
    logic            write_valid;
    logic            read_enable;
    regval_t         read_address;
    regval_t         read_data;
    logic            read_valid;
    logic            error;
    logic [AW-1:0]   mem_address;
    logic            mem_write;
    logic            mem_read;
    regval_t         mem_writedata;
    regval_t         mem_readdata;
    logic            mem_waitrequest;
    logic            mem_readdatavalid;
    mem_state_t      state;

    always #5 clock = ~clock;

    memory_responder #(
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO),
        .ERROR_WORD (32'hDEADBEEF)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .write_enable      (write_enable),
        .write_address     (write_address),
        .write_data        (write_data),
        .write_valid       (write_valid),
        .read_enable       (read_enable),
        .read_address      (read_address),
        .read_data         (read_data),
        .read_valid        (read_valid),
        .error             (error),
        .mem_address       (mem_address),
        .mem_write         (mem_write),
        .mem_read          (mem_read),
        .mem_writedata     (mem_writedata),
        .mem_readdata      (mem_readdata),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdatavalid (mem_readdatavalid),
        .state             (state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Entry: {is_read, error, data}; data is mem_writedata for stores, read_data for loads.
    logic [33:0] exp_q[$];
    logic [33:0] mon_obs;
    logic [33:0] mon_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        write_enable      = 1'b0;
        write_address     = '0;
        write_data        = '0;
        read_enable       = 1'b0;
        read_address      = '0;
        mem_readdata      = '0;
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b0;
    endtask

    // Completion monitor: every valid pulse must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && (write_valid || read_valid)) begin
            mon_obs = {read_valid, error, read_valid ? read_data : mem_writedata};
            check_eq("single_valid", 32'(write_valid & read_valid), 32'd0);
            check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check_eq("sb_kind", 32'(mon_obs[33:32]), 32'(mon_exp[33:32]));
                check_eq("sb_data", mon_obs[31:0], mon_exp[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int rd_cnt;
        int pulses;
        int valid_at;
        int first_rd;
        int wv_at;
        int rv_at;
        int wv_n;
        int rv_n;
        int err_n;
        int first_wr;
        int second_wr;
        logic rd_pending;
        logic err_with;
        logic [AW-1:0] addr2;

        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        check_eq("rst_state", 32'(state), 32'(IDLE));
        check_eq("rst_strobes", 32'({mem_write, mem_read}), 32'd0);
        check_eq("rst_pulses", 32'({write_valid, read_valid, error}), 32'd0);
        check_eq("rst_read_data", read_data, 32'd0);
        check_eq("rst_mem_address", 32'(mem_address), 32'd0);
        check_eq("rst_mem_writedata", mem_writedata, 32'd0);
        reset = 1'b0;
        tick();

        // Zero-wait store
        write_enable  = 1'b1;
        write_address = 32'h0000_0104;
        write_data    = 32'h1234_5678;
        exp_q.push_back({2'b00, 32'h1234_5678});
        tick();
        check_eq("st_mem_write_n1", 32'(mem_write), 32'd1);
        check_eq("st_mem_address", 32'(mem_address), 32'h041);
        check_eq("st_mem_writedata", mem_writedata, 32'h1234_5678);
        check_eq("st_valid_n1", 32'(write_valid), 32'd0);
        tick();
        check_eq("st_mem_write_n2", 32'(mem_write), 32'd0);
        check_eq("st_valid_n2", 32'(write_valid), 32'd1);
        write_enable = 1'b0;
        tick();
        check_eq("st_valid_n3", 32'(write_valid), 32'd0);
        check_eq("st_idle_n3", 32'(state), 32'(IDLE));

        // Load with 3 wait cycles and delayed read data
        read_enable     = 1'b1;
        read_address    = 32'h0000_0108;
        mem_waitrequest = 1'b1;
        exp_q.push_back({2'b10, 32'hCAFE_0001});
        rd_cnt = 0; pulses = 0; valid_at = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            mem_waitrequest   = (k <= 3);
            mem_readdatavalid = (k == 6);
            mem_readdata      = (k == 6) ? 32'hCAFE_0001 : $urandom;
            if (k == 1) check_eq("ld_mem_address", 32'(mem_address), 32'h042);
            if (mem_read) rd_cnt++;
            if (read_valid) begin
                pulses++;
                valid_at    = k;
                read_enable = 1'b0;
            end
        end
        mem_readdatavalid = 1'b0;
        check_eq("ld_read_cycles", 32'(rd_cnt), 32'd4);
        check_eq("ld_pulses", 32'(pulses), 32'd1);
        check_eq("ld_valid_at", 32'(valid_at), 32'd7);
        check_eq("ld_read_data", read_data, 32'hCAFE_0001);

        // Simultaneous store and load: store first, load after IDLE
        write_enable  = 1'b1;
        write_address = 32'h0000_0010;
        write_data    = 32'h0BAD_F00D;
        read_enable   = 1'b1;
        read_address  = 32'h0000_0020;
        exp_q.push_back({2'b00, 32'h0BAD_F00D});
        exp_q.push_back({2'b10, 32'hA5A5_0003});
        first_rd = -1; wv_at = -1; rv_at = -1; wv_n = 0; rv_n = 0; rd_pending = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            mem_waitrequest   = 1'b0;
            mem_readdatavalid = rd_pending;
            mem_readdata      = rd_pending ? 32'hA5A5_0003 : $urandom;
            rd_pending        = mem_read;
            if (mem_read && first_rd < 0) first_rd = k;
            if (write_valid) begin
                wv_n++;
                wv_at        = k;
                write_enable = 1'b0;
            end
            if (read_valid) begin
                rv_n++;
                rv_at       = k;
                read_enable = 1'b0;
            end
        end
        mem_readdatavalid = 1'b0;
        check_eq("both_wv_at", 32'(wv_at), 32'd2);
        check_eq("both_first_rd", 32'(first_rd), 32'd4);
        check_eq("both_rv_at", 32'(rv_at), 32'd6);
        check_eq("both_wv_n", 32'(wv_n), 32'd1);
        check_eq("both_rv_n", 32'(rv_n), 32'd1);

        // Load that never gets accepted: watchdog completes it
        read_enable     = 1'b1;
        read_address    = 32'h0000_0300;
        mem_waitrequest = 1'b1;
        exp_q.push_back({2'b11, 32'hDEAD_BEEF});
        rd_cnt = 0; valid_at = -1; err_with = 1'b0; err_n = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (mem_read) rd_cnt++;
            if (error) err_n++;
            if (read_valid) begin
                valid_at        = k;
                err_with        = error;
                read_enable     = 1'b0;
                mem_waitrequest = 1'b0;
            end
        end
        check_eq("to_valid_at", 32'(valid_at), 32'd9);
        check_eq("to_error_with_valid", 32'(err_with), 32'd1);
        check_eq("to_error_pulses", 32'(err_n), 32'd1);
        check_eq("to_read_cycles", 32'(rd_cnt), 32'd8);
        check_eq("to_read_data", read_data, 32'hDEAD_BEEF);

        // Reset during READ_WAIT, then stale read data arrives
        read_enable  = 1'b1;
        read_address = 32'h0000_0400;
        tick();
        check_eq("rr_read_req", 32'(state), 32'(READ_REQ));
        tick();
        check_eq("rr_read_wait", 32'(state), 32'(READ_WAIT));
        reset       = 1'b1;
        read_enable = 1'b0;
        tick();
        check_eq("rr_strobe_dropped", 32'(mem_read), 32'd0);
        check_eq("rr_state_idle", 32'(state), 32'(IDLE));
        reset             = 1'b0;
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'h7777_7777;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            mem_readdatavalid = 1'b0;
            if (read_valid) pulses++;
        end
        check_eq("rr_no_valid", 32'(pulses), 32'd0);
        check_eq("rr_read_data", read_data, 32'd0);
        check_eq("rr_state_after", 32'(state), 32'(IDLE));

        // Reset during a stalled store drops mem_write despite waitrequest
        write_enable    = 1'b1;
        write_address   = 32'h0000_0500;
        write_data      = 32'h5555_AAAA;
        mem_waitrequest = 1'b1;
        tick();
        check_eq("rw_mem_write", 32'(mem_write), 32'd1);
        tick();
        reset        = 1'b1;
        write_enable = 1'b0;
        tick();
        check_eq("rw_strobe_dropped", 32'(mem_write), 32'd0);
        check_eq("rw_mem_address", 32'(mem_address), 32'd0);
        check_eq("rw_mem_writedata", mem_writedata, 32'd0);
        reset           = 1'b0;
        mem_waitrequest = 1'b0;
        tick();

        // Back-to-back stores, second one wrapping the address
        write_enable  = 1'b1;
        write_address = 32'h0000_0200;
        write_data    = 32'h1111_2222;
        exp_q.push_back({2'b00, 32'h1111_2222});
        first_wr = -1; second_wr = -1; wv_n = 0; wv_at = -1; addr2 = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (mem_write) begin
                if (first_wr < 0) begin
                    first_wr = k;
                end else if (second_wr < 0) begin
                    second_wr = k;
                    addr2     = mem_address;
                end
            end
            if (write_valid) begin
                wv_n++;
                if (wv_n == 1) begin
                    wv_at         = k;
                    write_address = 32'hFFFF_FFFC;
                    write_data    = 32'h3333_4444;
                    exp_q.push_back({2'b00, 32'h3333_4444});
                end else begin
                    write_enable = 1'b0;
                end
            end
        end
        check_eq("b2b_first_valid", 32'(wv_at), 32'd2);
        check_eq("b2b_second_write", 32'(second_wr), 32'd4);
        check_eq("b2b_wrap_address", 32'(addr2), 32'h3FFF);
        check_eq("b2b_valid_count", 32'(wv_n), 32'd2);

        tick();
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
